// File: rtl/led_sweep_pkg.sv
// Shared types for the LED sweep engine: display modes, FSM states, sweep direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_DOT    = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Raw mode encoding 3 is unused and folds onto FILL.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_DOT;
            2'd2:    return MODE_BOUNCE;
            default: return MODE_FILL;
        endcase
    endfunction

endpackage

// File: rtl/led_sweep_btn_sync_debounce.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce (LED_SWEEP_DEBOUNCE_EN).
// Latency: 2 cycles; plus DEB_CYCLES when LED_SWEEP_DEBOUNCE_EN is defined.
// Backpressure: none, free-running level output.
import led_sweep_pkg::*;

module btn_sync_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_inp,
    output logic btn_s
);

    logic btn_meta;
    logic btn_sync;

    // Two-stage synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= button_inp;
            btn_sync <= btn_meta;
        end
    end

`ifdef LED_SWEEP_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] deb_cnt;

    // Accept a new level only after it has differed from the current one for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt <= '0;
            btn_s   <= 1'b0;
        end else if (btn_sync != btn_s) begin
            if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb_cnt <= '0;
                btn_s   <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end
`else
    assign btn_s = btn_sync;
`endif

endmodule

// File: rtl/led_sweep.sv
// LED sweep engine: FILL / DOT / BOUNCE chase while the button is held (debounce via LED_SWEEP_DEBOUNCE_EN).
// Latency: RUN two cycles after press is sampled; first LED step step_div+1 cycles later.
// Backpressure: none, outputs are free-running registered levels and a done pulse.
import led_sweep_pkg::*;

module led_sweep #(
    parameter int N_LEDS     = 8,
    parameter int DIV_W      = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button_inp,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    output logic [N_LEDS-1:0] led,
    output logic              busy,
    output logic              done
);

    localparam int PH_W  = $clog2(N_LEDS + 1);
    localparam int POS_W = $clog2(N_LEDS);

    logic              btn_s;
    state_e            state;
    mode_e             mode_q;
    logic [DIV_W-1:0]  pre_cnt;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_nxt;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_nxt;
    logic              dir;
    logic              dir_nxt;
    logic              tick;
    logic              wrap;
    logic [N_LEDS-1:0] led_nxt;

    btn_sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst        (rst),
        .button_inp (button_inp),
        .btn_s      (btn_s)
    );

    // Next step of the sweep and the LED pattern it produces, applied only on a tick.
    always_comb begin
        // >= keeps the prescaler from running away if step_div shrinks mid-count.
        tick    = (pre_cnt >= step_div);
        ph_nxt  = (ph == PH_W'(N_LEDS)) ? '0 : ph + PH_W'(1);
        pos_nxt = (dir == DIR_UP) ? pos + POS_W'(1) : pos - POS_W'(1);
        // Direction flips on arrival at an end, so each end LED shows for a single step.
        dir_nxt = dir;
        if (pos_nxt == POS_W'(N_LEDS - 1)) begin
            dir_nxt = DIR_DOWN;
        end else if (pos_nxt == '0) begin
            dir_nxt = DIR_UP;
        end
        led_nxt = '0;
        wrap    = 1'b0;
        case (mode_q)
            MODE_DOT: begin
                wrap = (ph == PH_W'(N_LEDS));
                for (int i = 0; i < N_LEDS; i++) begin
                    led_nxt[i] = (ph_nxt == PH_W'(i + 1));
                end
            end
            MODE_BOUNCE: begin
                wrap = (dir == DIR_DOWN) && (pos_nxt == '0);
                for (int i = 0; i < N_LEDS; i++) begin
                    led_nxt[i] = (pos_nxt == POS_W'(i));
                end
            end
            default: begin
                wrap = (ph == PH_W'(N_LEDS));
                for (int i = 0; i < N_LEDS; i++) begin
                    led_nxt[i] = (PH_W'(i) < ph_nxt);
                end
            end
        endcase
    end

    // Control FSM with prescaler, sweep counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_FILL;
            pre_cnt <= '0;
            ph      <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (btn_s) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        mode_q  <= decode_mode(mode);
                        pre_cnt <= '0;
                        ph      <= '0;
                        pos     <= '0;
                        dir     <= DIR_UP;
                        // BOUNCE lights its first LED immediately; FILL/DOT start dark.
                        led     <= (decode_mode(mode) == MODE_BOUNCE) ? N_LEDS'(1) : '0;
                    end
                end
                ST_RUN: begin
                    if (!btn_s) begin
                        // Release wins over any tick on the same edge.
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        pre_cnt <= '0;
                        ph      <= '0;
                        pos     <= '0;
                        dir     <= DIR_UP;
                        led     <= '0;
                    end else if (tick) begin
                        pre_cnt <= '0;
                        ph      <= ph_nxt;
                        pos     <= pos_nxt;
                        dir     <= dir_nxt;
                        led     <= led_nxt;
                        done    <= wrap;
                    end else begin
                        pre_cnt <= pre_cnt + DIV_W'(1);
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sweep.sv
// Self-checking bench for led_sweep: per-cycle expectations queued at stimulus time, popped on output.
// Latency: press/release latency modelled as LAT edges (adds DEB when LED_SWEEP_DEBOUNCE_EN).
// Backpressure: n/a.
module tb_led_sweep;

    localparam int N   = 8;
    localparam int DEB = 10;
`ifdef LED_SWEEP_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [N-1:0] led;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];

    logic         clk;
    logic         rst;
    logic         button_inp;
    logic [1:0]   mode;
    logic [15:0]  step_div;
    logic [N-1:0] led;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    led_sweep #(
        .N_LEDS     (N),
        .DIV_W      (16),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_inp (button_inp),
        .mode       (mode),
        .step_div   (step_div),
        .led        (led),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after edge E_k of a press whose first sampled high edge is E0
    // and which is released (sampled low) at E_hold.
    function automatic exp_t model(input logic [1:0] m, input int d, input int k, input int hold);
        exp_t e;
        int   j, t, ph, p, pos;
        logic tick_now;
        e = '0;
        if (k >= LAT && k < hold + LAT) begin
            e.busy   = 1'b1;
            j        = k - LAT;
            t        = j / (d + 1);
            tick_now = (j > 0) && (j % (d + 1) == 0);
            if (m == 2'd2) begin
                p      = t % (2 * N - 2);
                pos    = (p < N) ? p : 2 * N - 2 - p;
                e.led  = N'(1) << pos;
                e.done = tick_now && (p == 0);
            end else begin
                ph     = t % (N + 1);
                e.done = tick_now && (ph == 0);
                if (m == 2'd1) begin
                    e.led = (ph == 0) ? '0 : N'(1) << (ph - 1);
                end else begin
                    for (int i = 0; i < N; i++) e.led[i] = (i < ph);
                end
            end
        end
        return e;
    endfunction

    task automatic push_run(input logic [1:0] m, input int d, input int hold, input int len);
        for (int k = 0; k < len; k++) exp_q.push_back(model(m, d, k, hold));
    endtask

    task automatic start_press(input logic [1:0] m, input int d);
        @(negedge clk);
        mode       = m;
        step_div   = 16'(d);
        button_inp = 1'b1;
    endtask

    // Advance to just after edge E_k, releasing the button so that E_hold samples it low.
    task automatic drive_cycle(input int k, input int hold);
        if (k == hold) button_inp = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t got, e;
        rst        = 1'b0;
        button_inp = 1'b1;
        mode       = 2'd0;
        step_div   = 16'd0;
        for (int k = 0; k < 3; k++) exp_q.push_back('0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
        push_run(2'd0, 0, 6, 6 + LAT + 3);
        rst = 1'b1;
        for (int k = 0; k < 6 + LAT + 3; k++) begin
            drive_cycle(k, 6);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_fill();
        exp_t got, e;
        push_run(2'd0, 0, 20, 20 + LAT + 3);
        start_press(2'd0, 0);
        for (int k = 0; k < 20 + LAT + 3; k++) begin
            drive_cycle(k, 20);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fill k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_dot();
        exp_t got, e;
        push_run(2'd1, 3, 44, 44 + LAT + 3);
        start_press(2'd1, 3);
        for (int k = 0; k < 44 + LAT + 3; k++) begin
            drive_cycle(k, 44);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dot k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t got, e;
        push_run(2'd2, 0, 34, 34 + LAT + 3);
        start_press(2'd2, 0);
        for (int k = 0; k < 34 + LAT + 3; k++) begin
            drive_cycle(k, 34);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bounce k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    // Release mid-fill, then a fresh press must restart from 0x01.
    task automatic test_release_restart();
        exp_t got, e;
        push_run(2'd0, 0, 6, 6 + LAT + 3);
        push_run(2'd0, 0, 5, 5 + LAT + 3);
        start_press(2'd0, 0);
        for (int k = 0; k < 6 + LAT + 3; k++) begin
            drive_cycle(k, 6);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL release_mid k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
        start_press(2'd0, 0);
        for (int k = 0; k < 5 + LAT + 3; k++) begin
            drive_cycle(k, 5);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL restart k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    // Exit lands on the wrap edge: no done may be emitted.
    task automatic test_release_on_tick();
        exp_t got, e;
        push_run(2'd0, 0, 9, 9 + LAT + 3);
        start_press(2'd0, 0);
        for (int k = 0; k < 9 + LAT + 3; k++) begin
            drive_cycle(k, 9);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL release_on_tick k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    // Mode change during RUN is ignored; the following press picks it up.
    task automatic test_mode_switch();
        exp_t got, e;
        push_run(2'd0, 0, 20, 20 + LAT + 3);
        push_run(2'd1, 0, 12, 12 + LAT + 3);
        start_press(2'd0, 0);
        for (int k = 0; k < 20 + LAT + 3; k++) begin
            if (k == 8) mode = 2'd1;
            drive_cycle(k, 20);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mode_switch k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
        start_press(2'd1, 0);
        for (int k = 0; k < 12 + LAT + 3; k++) begin
            drive_cycle(k, 12);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mode_next_press k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    // Encoding 3 behaves as FILL; step_div=1 exercises a non-trivial prescaler.
    task automatic test_mode3();
        exp_t got, e;
        push_run(2'd3, 1, 24, 24 + LAT + 3);
        start_press(2'd3, 1);
        for (int k = 0; k < 24 + LAT + 3; k++) begin
            drive_cycle(k, 24);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mode3 k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    // Reset asserted between clock edges must clear outputs without a clock.
    task automatic test_async_reset();
        exp_t got, e;
        push_run(2'd0, 0, 1000, 8);
        start_press(2'd0, 0);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(k, 1000);
            got = {led, done, busy};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset k=%0d got led=%h done=%b busy=%b want led=%h done=%b busy=%b", k, got.led, got.done, got.busy, e.led, e.done, e.busy);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back('0);
        #1;
        got = {led, done, busy};
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL async_reset got led=%h done=%b busy=%b want led=%h done=%b busy=%b", got.led, got.done, got.busy, e.led, e.done, e.busy);
        end
        button_inp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 2) @(negedge clk);
    endtask

`ifdef LED_SWEEP_DEBOUNCE_EN
    task automatic test_debounce();
        logic saw;
        @(negedge clk);
        button_inp = 1'b1;
        repeat (5) @(negedge clk);
        button_inp = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL debounce_glitch got busy_seen=%b want 0", saw);
        end
        button_inp = 1'b1;
        repeat (12) @(negedge clk);
        button_inp = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_press got busy_seen=%b want 1", saw);
        end
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        button_inp = 1'b0;
        mode       = 2'd0;
        step_div   = 16'd0;
        test_reset();
        test_fill();
        test_dot();
        test_bounce();
        test_release_restart();
        test_release_on_tick();
        test_mode_switch();
        test_mode3();
        test_async_reset();
`ifdef LED_SWEEP_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_sweep.md
# led_sweep

Parametrised LED sweep engine for the LaunchPad front panel. It generalises the fixed 8-LED button-hold chase to `N_LEDS` outputs, a programmable step rate and three display modes: progressive fill, single dot and bounce. It also adds a busy flag and a done pulse for the sequencer above it. It sits between the raw push-button input and the LED pins.

## Interface
- `N_LEDS`, 8: number of LED outputs, 2..32.
- `DIV_W`, 16: width of the step divider.
- `DEB_CYCLES`, 1000: stable cycles required by the debouncer (used only with `LED_SWEEP_DEBOUNCE_EN`).
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `button_inp`, in, 1: raw push-button, asynchronous to `clk`, high = pressed.
- `mode`, in, 2: 0 FILL, 1 DOT, 2 BOUNCE, 3 treated as FILL.
- `step_div`, in, DIV_W: clock cycles per step minus one.
- `led`, out, N_LEDS: registered LED drive, bit 0 = LED 1.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse at the end of each sweep pass.

## Operation
- `button_inp` passes through a 2-flop synchroniser, producing `btn_s`.
- FSM states:
  - IDLE to RUN when `btn_s` = 1.
  - RUN to IDLE when `btn_s` = 0, from any phase. This also clears `led`, the phase counter, the prescaler and the direction.
- On IDLE to RUN, `mode` is latched into `mode_q`. A change of `mode` during RUN is ignored until the next press.
- Prescaler:
  - Cleared on RUN entry.
  - Counts 0..`step_div` and reloads, producing `tick` on the cycle where count = `step_div`.
  - `step_div` is re-read at every reload.
  - `step_div` = 0 gives a tick every cycle.
- FILL and DOT: phase counter `ph` runs 0..N_LEDS and is 0 on RUN entry. On each `tick`, `ph` goes to `ph`+1, and from N_LEDS it wraps to 0.
  - FILL: `led[i]` = 1 for i < `ph`.
  - DOT: only `led[ph-1]` = 1; all off when `ph` = 0.
  - The wrap N_LEDS to 0 asserts `done` and gives one dark step, matching the original chase restart.
- BOUNCE: position `pos` runs 0..N_LEDS-1 with direction `dir` (0 = up). `led` is one-hot at `pos` from RUN entry, so there is no dark step.
  - At `pos` = N_LEDS-1, `dir` flips to down.
  - At `pos` = 0 with `dir` = down, `dir` flips to up and `done` pulses.
  - Each end LED is held for one step only; the end positions are not repeated.
- `busy` = (state == RUN).
- Reset values: `led` = 0, `busy` = 0, `done` = 0, state IDLE, all counters 0, `dir` = up.

## Timing
- Reference point: `button_inp` rising is first sampled at edge E0.
  - `btn_s` is high after E1.
  - State is RUN and `busy` is 1 after E2.
  - The first tick edge is E2+`step_div`+1, at which `led` updates.
  - With `step_div` = 0 in FILL mode, `led` = 0x01 after E3 and 0xFF after E10 (N_LEDS = 8). `ph` returns to 0 at E11, where `led` = 0 and `done` = 1 for that cycle.
- Release of `button_inp` sampled at edge R0: `led` = 0 and `busy` = 0 after R2.
- Release on a tick edge: the exit to IDLE wins and no `done` is issued.
- Reset mid-run: all outputs are 0 immediately, with no wait for `clk`.

## Configuration
- `LED_SWEEP_DEBOUNCE_EN` defined: `btn_s` changes only after the synchronised input has differed from `btn_s` for `DEB_CYCLES` consecutive cycles. The counter restarts on any bounce. This adds `DEB_CYCLES` cycles to the press and release latencies.
- `LED_SWEEP_DEBOUNCE_EN` not defined: 2-flop synchroniser only, with the latencies given in Timing.

## Structure
- Package `led_sweep_pkg` holds:
  - the mode enum (FILL, DOT, BOUNCE);
  - the FSM state enum (IDLE, RUN);
  - the direction constants (UP, DOWN).
- Sub-module `btn_sync_debounce` contains the synchroniser and the optional debounce counter. Parameter: `DEB_CYCLES`. Output: `btn_s`.
- `led_sweep` itself contains the FSM, the prescaler, the phase/position counters and the output register.

## Test plan
- Reset with `button_inp` = 1 held: all outputs 0 while `rst` = 0. After release of `rst`, `busy` = 1 two cycles later.
- FILL, N_LEDS = 8, `step_div` = 0, button held 20 cycles:
  - `led` = 0x01, 0x03, …, 0xFF, then 0x00 with a `done` pulse.
  - The pattern then repeats from 0x01.
- DOT, `step_div` = 3, held: `led` goes one-hot 0x01, 0x02, … with each value held 4 cycles.
- BOUNCE, N_LEDS = 4, `step_div` = 0: `led` = 1,2,4,8,4,2,1,2,…, with `done` asserted on the cycle `led` returns to 1.
- Release at `ph` = 5 in FILL mode: `led` = 0 and `busy` = 0 two cycles after release. The next press restarts from `led` = 0x01.
- `mode` switched from FILL to DOT mid-run: the pattern stays FILL until release; the next press runs DOT.
- With `LED_SWEEP_DEBOUNCE_EN` and `DEB_CYCLES` = 10: a 5-cycle glitch on `button_inp` leaves `busy` at 0. A 12-cycle press gives `busy` = 1.
